// File: rtl/io_uart_bridge.sv
// io_uart_bridge: IO-port mapped UART with TX/RX FIFOs, sticky error flags and irq.
// Ports: clk100/reset (sync, active-high); IO_port_ID, IO_write_data, IO_write_strobe,
//   IO_read_strobe from the processor, IO_read_data combinational read mux back;
//   uart_tx serial out (idle high), uart_rx serial in (asynchronous); irq registered.
// Port map: BASE+0 data, BASE+1 RX present, BASE+2 TX full, BASE+3 {tx_drop, frame_err, rx_ovf}.
// Build option: define UART_LOOPBACK_EN to feed the RX FSM from the internal uart_tx.
module io_uart_bridge #(
   parameter logic [7:0] BASE_PORT    = 8'h01,
   parameter int         CLKS_PER_BIT = 868,
   parameter int         TX_DEPTH     = 16,
   parameter int         RX_DEPTH     = 16
) (
   input  logic       clk100,
   input  logic       reset,
   input  logic [7:0] IO_port_ID,
   input  logic [7:0] IO_write_data,
   input  logic       IO_write_strobe,
   input  logic       IO_read_strobe,
   output logic [7:0] IO_read_data,
   output logic       uart_tx,
   input  logic       uart_rx,
   output logic       irq
);
   localparam int TAW = $clog2(TX_DEPTH);
   localparam int RAW = $clog2(RX_DEPTH);
   localparam int CW  = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0]  C_END = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0]  C_MID = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0]  C_ONE = CW'(1);
   localparam logic [TAW:0]   T_ONE = (TAW+1)'(1);
   localparam logic [RAW:0]   R_ONE = (RAW+1)'(1);
   localparam logic [7:0]     P_RXP = BASE_PORT + 8'd1;
   localparam logic [7:0]     P_TXF = BASE_PORT + 8'd2;
   localparam logic [7:0]     P_ERR = BASE_PORT + 8'd3;
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
   logic [7:0]    tx_mem [TX_DEPTH];
   logic [7:0]    rx_mem [RX_DEPTH];
   logic [TAW:0]  tx_wp, tx_rp;
   logic [RAW:0]  rx_wp, rx_rp;
   logic          tx_empty, tx_full, rx_empty, rx_full;
   logic          wr_data, tx_push, tx_pop, rx_push, rx_pop, err_clr;
   logic          tx_drop, frame_err, rx_ovf, ferr_set, ovf_set;
   logic          rx_s1, rx_s2, rx_in;
   state_t        tx_st, tx_nx, rx_st, rx_nx;
   logic [CW-1:0] tx_cnt, rx_cnt;
   logic [2:0]    tx_bit, rx_bit;
   logic [7:0]    tx_sh, rx_sh;
   logic          tx_end, tx_o, rx_end, rx_mid, rx_prev, rx_done;
   // The wrap bit differs and the index matches exactly when the FIFO is full.
   assign tx_empty = tx_wp == tx_rp;
   assign rx_empty = rx_wp == rx_rp;
   assign tx_full  = (tx_wp ^ tx_rp) == {1'b1, {TAW{1'b0}}};
   assign rx_full  = (rx_wp ^ rx_rp) == {1'b1, {RAW{1'b0}}};
   assign wr_data  = IO_write_strobe && IO_port_ID == BASE_PORT;
   assign tx_push  = wr_data && !tx_full;
   assign rx_pop   = IO_read_strobe && IO_port_ID == BASE_PORT && !rx_empty;
   assign err_clr  = IO_read_strobe && IO_port_ID == P_ERR;
   assign IO_read_data = IO_port_ID == BASE_PORT ? (rx_empty ? 8'h00 : rx_mem[rx_rp[RAW-1:0]]) :
                         IO_port_ID == P_RXP ? {8{!rx_empty}} :
                         IO_port_ID == P_TXF ? {8{tx_full}} :
                         IO_port_ID == P_ERR ? {5'b0, tx_drop, frame_err, rx_ovf} : 8'hFF;
`ifdef UART_LOOPBACK_EN
   logic unused_rx;
   assign unused_rx = rx_s2;
   assign rx_in     = uart_tx;
`else
   assign rx_in = rx_s2;
`endif
   always_ff @(posedge clk100) begin
      if (tx_push) tx_mem[tx_wp[TAW-1:0]] <= IO_write_data;
      if (rx_push) rx_mem[rx_wp[RAW-1:0]] <= rx_sh;
   end
   always_ff @(posedge clk100) begin
      if (reset) begin
         tx_wp     <= '0;
         tx_rp     <= '0;
         rx_wp     <= '0;
         rx_rp     <= '0;
         tx_drop   <= 1'b0;
         frame_err <= 1'b0;
         rx_ovf    <= 1'b0;
         irq       <= 1'b0;
         rx_s1     <= 1'b1;
         rx_s2     <= 1'b1;
      end else begin
         rx_s1     <= uart_rx;
         rx_s2     <= rx_s1;
         tx_wp     <= tx_push ? tx_wp + T_ONE : tx_wp;
         tx_rp     <= tx_pop ? tx_rp + T_ONE : tx_rp;
         rx_wp     <= rx_push ? rx_wp + R_ONE : rx_wp;
         rx_rp     <= rx_pop ? rx_rp + R_ONE : rx_rp;
         // A clearing read loses to an error raised in the same cycle.
         tx_drop   <= (tx_drop && !err_clr) || (wr_data && tx_full);
         frame_err <= (frame_err && !err_clr) || ferr_set;
         rx_ovf    <= (rx_ovf && !err_clr) || ovf_set;
         irq       <= !rx_empty || tx_drop || frame_err || rx_ovf;
      end
   end
   assign tx_end = tx_cnt == C_END;
   always_ff @(posedge clk100) begin
      if (reset) begin
         tx_st   <= IDLE;
         tx_cnt  <= '0;
         tx_bit  <= '0;
         tx_sh   <= '0;
         uart_tx <= 1'b1;
      end else begin
         tx_st   <= tx_nx;
         tx_cnt  <= (tx_st == IDLE || tx_end) ? '0 : tx_cnt + C_ONE;
         tx_bit  <= tx_st != DATA ? 3'd0 : tx_end ? tx_bit + 3'd1 : tx_bit;
         tx_sh   <= tx_pop ? tx_mem[tx_rp[TAW-1:0]] : (tx_st == DATA && tx_end) ? tx_sh >> 1 : tx_sh;
         uart_tx <= tx_o;
      end
   end
   always_comb begin
      tx_nx = tx_st;
      case (tx_st)
         IDLE:    if (!tx_empty) tx_nx = START;
         START:   if (tx_end) tx_nx = DATA;
         DATA:    if (tx_end && tx_bit == 3'd7) tx_nx = STOP;
         STOP:    if (tx_end) tx_nx = tx_empty ? IDLE : START;
         default: tx_nx = IDLE;
      endcase
   end
   // Line level is registered, so the start bit appears one cycle after START is entered.
   always_comb begin
      tx_o   = tx_st == START ? 1'b0 : tx_st == DATA ? tx_sh[0] : 1'b1;
      tx_pop = !tx_empty && (tx_st == IDLE || (tx_st == STOP && tx_end));
   end
   // The start bit is checked half a bit in; data and stop are then sampled a full bit apart.
   assign rx_mid = rx_st == START && rx_cnt == C_MID;
   assign rx_end = rx_cnt == C_END;
   always_ff @(posedge clk100) begin
      if (reset) begin
         rx_st   <= IDLE;
         rx_prev <= 1'b1;
         rx_cnt  <= '0;
         rx_bit  <= '0;
         rx_sh   <= '0;
      end else begin
         rx_st   <= rx_nx;
         rx_prev <= rx_in;
         rx_cnt  <= (rx_st == IDLE || rx_mid || rx_end) ? '0 : rx_cnt + C_ONE;
         rx_bit  <= rx_st != DATA ? 3'd0 : rx_end ? rx_bit + 3'd1 : rx_bit;
         rx_sh   <= (rx_st == DATA && rx_end) ? {rx_in, rx_sh[7:1]} : rx_sh;
      end
   end
   always_comb begin
      rx_nx = rx_st;
      case (rx_st)
         IDLE:    if (rx_prev && !rx_in) rx_nx = START;
         START:   if (rx_mid) rx_nx = rx_in ? IDLE : DATA;
         DATA:    if (rx_end && rx_bit == 3'd7) rx_nx = STOP;
         STOP:    if (rx_end) rx_nx = IDLE;
         default: rx_nx = IDLE;
      endcase
   end
   always_comb begin
      rx_done  = rx_st == STOP && rx_end;
      rx_push  = rx_done && rx_in && !rx_full;
      ovf_set  = rx_done && rx_in && rx_full;
      ferr_set = rx_done && !rx_in;
   end
endmodule
